// File: rtl/vga_capture_if.sv
// Framebuffer write bus between the capture block and the memory controller.
interface vga_capture_if;
    logic [18:0] memAddr;
    logic [11:0] memData;
    logic        memWe;
    logic        memReady;

    modport master (output memAddr, output memData, output memWe, input memReady);
    modport slave  (input memAddr, input memData, input memWe, output memReady);
endinterface

// File: rtl/vga_capture.sv
// VGA frame capture into a framebuffer through a 4-entry write FIFO.
// Define VGA_CAPTURE_DECIMATE_EN to keep only even-x/even-y pixels (half resolution).
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BP     = 48,
    parameter int V_BP     = 33
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        vidIn,
    input  logic               HSyncIn,
    input  logic               VSyncIn,
    input  logic               pixEn,
    input  logic               captureEn,
    input  logic               clrOvf,
    vga_capture_if.master      mem,
    output logic               frameDone,
    output logic               overflow,
    output logic               busy
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_VS = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    localparam logic [10:0] H_START_C = 11'(H_BP);
    localparam logic [10:0] H_END_C   = 11'(H_BP + H_ACTIVE);
    localparam logic [10:0] H_LAST_C  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_START_C = 10'(V_BP);
    localparam logic [9:0]  V_END_C   = 10'(V_BP + V_ACTIVE);
    localparam logic [9:0]  V_LAST_C  = 10'(V_ACTIVE - 1);

    logic [11:0] vid_r;
    logic        hs_r, vs_r, pe_r, hs_q_r, vs_q_r;
    logic [10:0] hcnt_r, hpos_s, x_s;
    logic [9:0]  vcnt_r, y_s;
    logic        hs_rise_s, hs_fall_s, vs_rise_s, vs_fall_s;
    logic        pix_act_s, pick_s, last_pix_s, push_req_s;
    logic [1:0]  state_r, state_nxt_s;
    logic        done_s;
    logic [11:0] fifo_r [4];
    logic [1:0]  wr_ptr_r, rd_ptr_r;
    logic [2:0]  cnt_r, cnt_nxt_s;
    logic        full_s, push_s, pop_s, drop_s, start_s;
    logic [18:0] addr_r;
    logic        we_r, done_r, ovf_r, busy_r;

    // Input sampling register; syncs idle high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_r <= 12'd0;
            hs_r  <= 1'b1;
            vs_r  <= 1'b1;
            pe_r  <= 1'b0;
        end else begin
            vid_r <= vidIn;
            hs_r  <= HSyncIn;
            vs_r  <= VSyncIn;
            pe_r  <= pixEn;
        end
    end

    // Previous qualified sync levels for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q_r <= 1'b1;
            vs_q_r <= 1'b1;
        end else if (pe_r) begin
            hs_q_r <= hs_r;
            vs_q_r <= vs_r;
        end else begin
            hs_q_r <= hs_q_r;
            vs_q_r <= vs_q_r;
        end
    end

    assign hs_rise_s = pe_r & hs_r & ~hs_q_r;
    assign hs_fall_s = pe_r & ~hs_r & hs_q_r;
    assign vs_rise_s = pe_r & vs_r & ~vs_q_r;
    assign vs_fall_s = pe_r & ~vs_r & vs_q_r;

    // Position of the current sample: the HSync deassert sample is pixel 0
    always_comb begin
        hpos_s    = hs_rise_s ? 11'd0 : hcnt_r;
        x_s       = hpos_s - H_START_C;
        y_s       = vcnt_r - V_START_C;
        pix_act_s = pe_r && (hpos_s >= H_START_C) && (hpos_s < H_END_C)
                         && (vcnt_r >= V_START_C) && (vcnt_r < V_END_C);
`ifdef VGA_CAPTURE_DECIMATE_EN
        pick_s    = pix_act_s & ~x_s[0] & ~y_s[0];
`else
        pick_s    = pix_act_s;
`endif
        last_pix_s = pix_act_s && (x_s == H_LAST_C) && (y_s == V_LAST_C);
        push_req_s = (state_r == ST_CAPTURE) && pick_s;
    end

    // Horizontal and line counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_r <= 11'd0;
            vcnt_r <= 10'd0;
        end else begin
            if (pe_r) hcnt_r <= hpos_s + 11'd1;
            else      hcnt_r <= hcnt_r;
            if (vs_rise_s)      vcnt_r <= 10'd0;
            else if (hs_fall_s) vcnt_r <= vcnt_r + 10'd1;
            else                vcnt_r <= vcnt_r;
        end
    end

    // FIFO control; a full FIFO still accepts a push when it pops in the same cycle
    always_comb begin
        full_s  = (cnt_r == 3'd4);
        pop_s   = we_r & mem.memReady;
        push_s  = push_req_s & (~full_s | pop_s);
        drop_s  = push_req_s & full_s & ~pop_s;
        start_s = (state_r == ST_WAIT_VS) && vs_fall_s;
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + 3'd1;
            2'b01:   cnt_nxt_s = cnt_r - 3'd1;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) fifo_r[i] <= 12'd0;
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            cnt_r    <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= vid_r;
                wr_ptr_r         <= wr_ptr_r + 2'd1;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + 2'd1;
            cnt_r <= cnt_nxt_s;
        end
    end

    // Capture sequencing
    always_comb begin
        state_nxt_s = state_r;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE:    if (captureEn) state_nxt_s = ST_WAIT_VS;
                        else           state_nxt_s = ST_IDLE;
            ST_WAIT_VS: if (vs_fall_s) state_nxt_s = ST_CAPTURE;
                        else           state_nxt_s = ST_WAIT_VS;
            ST_CAPTURE: if (last_pix_s || vs_fall_s) state_nxt_s = ST_DRAIN;
                        else                         state_nxt_s = ST_CAPTURE;
            ST_DRAIN: begin
                if (cnt_r == 3'd0) begin
                    done_s      = 1'b1;
                    state_nxt_s = captureEn ? ST_WAIT_VS : ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State, address and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= 19'd0;
            we_r    <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (start_s)    addr_r <= 19'd0;
            else if (pop_s) addr_r <= addr_r + 19'd1;
            else            addr_r <= addr_r;
            we_r   <= (cnt_nxt_s != 3'd0);
            done_r <= done_s;
            if (drop_s)      ovf_r <= 1'b1;
            else if (clrOvf) ovf_r <= 1'b0;
            else             ovf_r <= ovf_r;
            busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

    assign mem.memAddr = addr_r;
    assign mem.memData = fifo_r[rd_ptr_r];
    assign mem.memWe   = we_r;
    assign frameDone   = done_r;
    assign overflow    = ovf_r;
    assign busy        = busy_r;
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640 (active pixels per line); V_ACTIVE 480 (active lines per frame); H_BP 48 (qualified pixels from HSync deassert to first active pixel); V_BP 33 (lines from VSync deassert to first active line).
REQ-002 clk input 1: single clock for all logic.
REQ-003 rst input 1: asynchronous, active-high reset.
REQ-004 vidIn input 12: RGB444 pixel data.
REQ-005 HSyncIn input 1: horizontal sync, active low.
REQ-006 VSyncIn input 1: vertical sync, active low.
REQ-007 pixEn input 1: pixel qualifier; all stream inputs are sampled only when it is high.
REQ-008 captureEn input 1: level; arms capture.
REQ-009 clrOvf input 1: pulse; clears the overflow flag.
REQ-010 memAddr output 19: framebuffer word address.
REQ-011 memData output 12: pixel written to the framebuffer.
REQ-012 memWe output 1: write request.
REQ-013 memReady input 1: write accepted in any cycle where memWe and memReady are both high.
REQ-014 frameDone output 1: one-cycle pulse when a frame is fully written.
REQ-015 overflow output 1: sticky flag; a pixel was dropped.
REQ-016 busy output 1: high in every state except IDLE.

Function
REQ-017 vidIn, HSyncIn, VSyncIn and pixEn SHALL be registered once before use; all edge detection uses qualified (pixEn) registered samples.
REQ-018 Horizontal counter SHALL clear on a qualified HSync rising edge and increment once per qualified sample.
- A pixel is active when hcnt is in [H_BP, H_BP+H_ACTIVE).
REQ-019 Line counter SHALL clear on a qualified VSync rising edge and increment on each qualified HSync falling edge.
- A line is active when vcnt is in [V_BP, V_BP+V_ACTIVE).
REQ-020 FSM states SHALL be IDLE, WAIT_VS, CAPTURE, DRAIN.
- IDLE->WAIT_VS when captureEn=1.
- WAIT_VS->CAPTURE on a qualified VSync falling edge; memAddr restarts at 0.
- CAPTURE->DRAIN after the last active pixel of the last active line is pushed.
- DRAIN->WAIT_VS when the FIFO is empty and the last write is accepted, if captureEn=1; otherwise DRAIN->IDLE.
REQ-021 captureEn deasserted during CAPTURE SHALL NOT abort the frame; it takes effect at DRAIN exit.
REQ-022 Active pixels SHALL be pushed into a 4-entry FIFO; memWe=1 whenever the FIFO is non-empty; memData is the FIFO head.
REQ-023 On acceptance, the FIFO SHALL pop and memAddr SHALL increment by 1; memAddr and memData hold stable while memWe=1 and memReady=0.
REQ-024 A push and a pop in the same cycle SHALL both occur, with FIFO occupancy unchanged.
REQ-025 A push while the FIFO is full and not popping SHALL drop the pixel and set overflow; memAddr is not advanced for a dropped pixel.
REQ-026 clrOvf SHALL clear overflow; if clrOvf and a new drop occur in the same cycle, overflow=1.
REQ-027 frameDone SHALL pulse in the cycle DRAIN exits; latency from pixel sample to memWe is 2 cycles (input register plus FIFO write).
REQ-028 A VSync falling edge seen during CAPTURE before the frame completes SHALL move the FSM to DRAIN; frameDone still pulses.

Reset
REQ-029 On rst: state=IDLE, FIFO empty, memWe=0, memAddr=0, memData=0, frameDone=0, overflow=0, busy=0, counters=0, input registers=0 (syncs registered as 1, i.e. inactive).
REQ-030 rst asserted mid-frame SHALL abandon all outstanding FIFO data immediately.

Configuration
REQ-031 Macro VGA_CAPTURE_DECIMATE_EN defined: only active pixels with even x and even y are pushed, giving 320x240 = 76800 writes per frame, memAddr 0..76799.
- Undefined: every active pixel is pushed, giving 307200 writes per frame, memAddr 0..307199.

Verification
REQ-032 640x480 frame, pixEn=1, memReady=1, vidIn=x[11:0]: 307200 writes, addr N carries data N%640, one frameDone, overflow=0.
REQ-033 Same frame with memReady low 1 of every 2 cycles: overflow=1 and fewer than 307200 writes; then clrOvf pulse -> overflow=0.
REQ-034 memReady held 0 for 3 cycles mid-line with pixEn 1-in-4: no drop; memAddr and memData stable throughout the stall.
REQ-035 captureEn dropped mid-frame: frame completes, frameDone pulses, FSM returns to IDLE, busy=0.
REQ-036 rst asserted at line 100: memWe=0 and memAddr=0 in the same cycle; next frame restarts at address 0.
REQ-037 With VGA_CAPTURE_DECIMATE_EN: exactly 76800 writes; last memAddr=76799.
